// File: rtl/alu_divider_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: funct3 codes and FSM states.
package alu_divider_pkg;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_divider_abs_negate.sv
// Conditional two's-complement negate, used for operand magnitude and result sign fix.
module alu_divider_abs_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with a start/busy/done handshake.
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, next_state;

  logic [WIDTH-1:0] rem, quo, divisor;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r, sel_rem;

  logic             load, step, finish, busy_d, done_d;

  // instr[30] plays no part in the divide group
  logic unused_funccode_bit3;
  assign unused_funccode_bit3 = FuncCode[3];

  logic is_div_op, is_signed, is_rem, b_zero, overflow, fast, accept, cnt_zero;
  assign is_div_op = FuncCode[2:0] inside {DIV, DIVU, REM, REMU};
  assign is_signed = (FuncCode[2:0] == DIV) || (FuncCode[2:0] == REM);
  assign is_rem    = (FuncCode[2:0] == REM) || (FuncCode[2:0] == REMU);
  assign b_zero    = (B == '0);
  assign overflow  = is_signed && (A == MIN_NEG) && (B == '1);
  assign fast      = b_zero || overflow;
  assign accept    = start && (state == IDLE) && is_div_op;
  assign cnt_zero  = (cnt == '0);

  logic [WIDTH-1:0] abs_a, abs_b, fixed_q, fixed_r;

  alu_divider_abs_negate #(.WIDTH(WIDTH)) u_abs_a (
    .value(A), .negate(is_signed && A[WIDTH-1]), .result_c(abs_a)
  );
  alu_divider_abs_negate #(.WIDTH(WIDTH)) u_abs_b (
    .value(B), .negate(is_signed && B[WIDTH-1]), .result_c(abs_b)
  );
  alu_divider_abs_negate #(.WIDTH(WIDTH)) u_fix_q (
    .value(quo), .negate(sign_q), .result_c(fixed_q)
  );
  alu_divider_abs_negate #(.WIDTH(WIDTH)) u_fix_r (
    .value(rem), .negate(sign_r), .result_c(fixed_r)
  );

  // One restoring step: partial remainder never exceeds 2*divisor, so WIDTH+1 bits suffice
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] sub;
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, divisor});
  assign sub     = shifted[WIDTH-1:0] - divisor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = fast ? FIX : RUN;
      RUN:     if (cnt_zero) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:    load   = accept;
      RUN:     step   = 1'b1;
      FIX:     finish = 1'b1;
      default: ;
    endcase
    busy_d = (next_state != IDLE);
    done_d = finish;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      sel_rem <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (load) begin
        sel_rem <= is_rem;
        divisor <= abs_b;
        cnt     <= '0;
        if (b_zero) begin
          quo    <= '1;
          rem    <= A;
          sign_q <= 1'b0;
          sign_r <= 1'b0;
        end else if (overflow) begin
          quo    <= MIN_NEG;
          rem    <= '0;
          sign_q <= 1'b0;
          sign_r <= 1'b0;
        end else begin
          quo    <= abs_a;
          rem    <= '0;
          sign_q <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          sign_r <= is_signed && A[WIDTH-1];
          cnt    <= CNT_W'(WIDTH - 1);
        end
      end
      if (step) begin
        rem <= ge ? sub : shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
        if (!cnt_zero) cnt <= cnt - CNT_W'(1);
      end
      if (finish) result <= sel_rem ? fixed_r : fixed_q;
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Randomized and directed check of alu_divider against a latency/arithmetic model.
module tb_alu_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [3:0]  fc = 4'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  alu_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .FuncCode(fc),
    .A(a), .B(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Architectural result of an RV32M divide-group instruction
  function automatic logic [31:0] ref_value(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    logic ovf;
    sx = x;
    sy = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sx / sy);
      3'b101:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110:  return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    bit sgn;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    if (y == 0 || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Model: pending op completes a fixed number of edges after acceptance
  bit          m_busy = 0, m_done = 0, pending = 0;
  logic [31:0] m_result = '0, pend_val = '0;
  int          m_edge = 0, due = 0;

  always @(posedge clk or posedge reset) begin
    bit acc;
    if (reset) begin
      m_busy = 0; m_done = 0; m_result = '0; pending = 0;
    end else begin
      acc = start && !m_busy && fc[2];
      m_edge++;
      m_done = 0;
      if (pending && m_edge == due) begin
        m_done = 1; m_result = pend_val; pending = 0;
      end
      if (acc) begin
        pending  = 1;
        pend_val = ref_value(fc[2:0], a, b);
        due      = m_edge + ref_latency(fc[2:0], a, b);
      end
      m_busy = pending;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", result, m_result);
    end
  end

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rnd_fc();
    logic [2:0] f3;
    f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'(4 + $urandom_range(0, 3));
    return {1'($urandom), f3};
  endfunction

  task automatic run_op(input string name, input logic [3:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int t0;
    bit seen;
    seen = 0;
    @(negedge clk);
    start = 1; fc = f; a = x; b = y;
    @(posedge clk); #1;
    t0 = cyc;
    start = 0; fc = 4'($urandom); a = $urandom; b = $urandom;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        chk({name, " result"}, result, exp);
        chk({name, " latency"}, 32'(cyc - t0), 32'(exp_lat));
      end
    end
    if (!seen) chk({name, " done timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("idle timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;

    run_op("divu 100/7", 4'b0101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu 100/7", 4'b0111, 32'd100, 32'd7, 32'd2, 33);
    run_op("div -100/7", 4'b0100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("rem -100/7", 4'b1110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("divu 5/0", 4'b0101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem -5/0", 4'b0110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op("div ovf", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // start held through a whole op: next op accepted in the done cycle
    @(negedge clk);
    start = 1; fc = 4'b0101; a = 32'd100; b = 32'd7;
    n = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("held start done count", 32'(n), 32'd2);
    @(negedge clk);
    start = 0;
    wait_idle();

    // non-divide FuncCode is ignored
    @(negedge clk);
    start = 1; fc = 4'b0000; a = 32'd10; b = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("nondiv busy", 32'(busy), 32'd0);
      chk("nondiv done", 32'(done), 32'd0);
    end
    @(negedge clk);
    start = 0;

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1; fc = 4'b0101; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrun reset busy", 32'(busy), 32'd0);
    chk("midrun reset done", 32'(done), 32'd0);
    chk("midrun reset result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("no done after reset", 32'(n), 32'd0);
    run_op("divu 9/3", 4'b0101, 32'd9, 32'd3, 32'd3, 33);

    // randomized traffic, including start while busy and non-divide codes
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      fc = rnd_fc();
      a = rnd_operand();
      b = rnd_operand();
    end
    @(negedge clk);
    start = 0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
